// File: rtl/multi_channel_clock_divider.sv
// Multi-channel runtime-programmable clock divider with period-boundary updates.
// Ports: clk_in/reset, enable/divisor/sync per channel in; clk_out/tick/running out.
module multi_channel_clock_divider #(
   parameter int NUM_CH = 2,
   parameter int WIDTH  = 8
) (
   input  logic                      clk_in,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         enable,
   input  logic [NUM_CH*WIDTH-1:0]   divisor,
   input  logic                      sync,
   output logic [NUM_CH-1:0]         clk_out,
   output logic [NUM_CH-1:0]         tick,
   output logic [NUM_CH-1:0]         running
);

   localparam int W1 = WIDTH + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e           st_q, st_d;
      logic [WIDTH-1:0] d_q, d_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;

      logic [WIDTH-1:0] div;
      logic             start_ok;
      logic             boundary;
      logic             reload;
      logic [W1-1:0]    half;
      logic [W1-1:0]    cnt_nx;

      assign div      = divisor[c*WIDTH +: WIDTH];
      assign start_ok = enable[c] && (div >= WIDTH'(2));
      // Only meaningful while running, where D >= 2 holds.
      assign boundary = (cnt_q == d_q - WIDTH'(1));
      // High phase length ceil(D/2), one extra bit so D = 2^WIDTH-1 fits.
      assign half     = ({1'b0, d_q} + W1'(1)) >> 1;
      assign cnt_nx   = {1'b0, cnt_q} + W1'(1);
      // Divisor/enable are only looked at when idle, at a boundary or on sync.
      assign reload   = sync || (st_q == ST_IDLE) || boundary;

      always_comb begin
         st_d   = st_q;
         d_d    = d_q;
         cnt_d  = cnt_q;
         clk_d  = clk_q;
         tick_d = 1'b0;
         if (reload) begin
            if (start_ok) begin
               st_d   = ST_RUN;
               d_d    = div;
               cnt_d  = '0;
               clk_d  = 1'b1;
               tick_d = 1'b1;
            end else begin
               st_d  = ST_IDLE;
               cnt_d = '0;
               clk_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_nx[WIDTH-1:0];
            clk_d = (cnt_nx < half);
         end
      end

      always_ff @(posedge clk_in or posedge reset) begin
         if (reset) begin
            st_q   <= ST_IDLE;
            d_q    <= '0;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
         end
      end

      assign clk_out[c] = clk_q;
      assign tick[c]    = tick_q;
      assign running[c] = (st_q == ST_RUN);
   end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench for multi_channel_clock_divider (NUM_CH=2, WIDTH=8).
// Vector table plus hand sequences for async reset and maximum divisor.
module tb_multi_channel_clock_divider;

   typedef struct packed {
      logic       rst;
      logic [1:0] en;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       sy;
      logic [1:0] eclk;
      logic [1:0] etick;
      logic [1:0] erun;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  en;
   logic [15:0] divisor;
   logic        sy;
   logic [1:0]  clk_out;
   logic [1:0]  tick;
   logic [1:0]  running;

   int n_vec = 0;
   int n_err = 0;

   vec_t tbl[$];
   vec_t sb[$];

   multi_channel_clock_divider #(.NUM_CH(2), .WIDTH(8)) dut (
      .clk_in  (clk),
      .reset   (rst),
      .enable  (en),
      .divisor (divisor),
      .sync    (sy),
      .clk_out (clk_out),
      .tick    (tick),
      .running (running)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rs, input logic [1:0] e, input logic [7:0] a,
      input logic [7:0] b, input logic s, input logic [1:0] c,
      input logic [1:0] t, input logic [1:0] r);
      vec_t v;
      v.rst = rs; v.en = e; v.d0 = a; v.d1 = b; v.sy = s;
      v.eclk = c; v.etick = t; v.erun = r;
      return v;
   endfunction

   task automatic check(input string nm, input vec_t v);
      n_vec++;
      if ({clk_out, tick, running} !== {v.eclk, v.etick, v.erun}) begin
         n_err++;
         $display("FAIL %s: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                  nm, clk_out, tick, running, v.eclk, v.etick, v.erun);
      end
   endtask

   task automatic step(input string nm, input vec_t v);
      vec_t e;
      @(negedge clk);
      rst = v.rst; en = v.en; divisor = {v.d1, v.d0}; sy = v.sy;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(nm, e);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 2'b11; divisor = {8'd4, 8'd4}; sy = 1'b0;

      // Reset held with start conditions present.
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1, 2'b11, 4, 4, 0, 2'b00, 2'b00, 2'b00));
      // D=4 on ch0, D=3 on ch1.
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b10, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b11, 2'b01, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b10, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b10, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b01, 2'b01, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b11, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b10, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 4, 3, 0, 2'b00, 2'b00, 2'b11));
      // D=2 toggling on both.
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 2'b00, 2'b11));
      // ch0 D=6, divisor switched to 2 mid-period.
      tbl.push_back(mk(0, 2'b11, 6, 2, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b11, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b10, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 2, 2, 0, 2'b00, 2'b00, 2'b11));
      // ch0 D=8, enable dropped at cnt=1.
      tbl.push_back(mk(0, 2'b11, 8, 2, 0, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b11, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b10, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b10, 2'b10, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b10, 2'b10, 2'b10));
      tbl.push_back(mk(0, 2'b10, 8, 2, 0, 2'b00, 2'b00, 2'b10));
      // Invalid divisors 1 and 0 never start ch0.
      tbl.push_back(mk(0, 2'b11, 1, 2, 0, 2'b10, 2'b10, 2'b10));
      tbl.push_back(mk(0, 2'b11, 0, 2, 0, 2'b00, 2'b00, 2'b10));
      // ch1 D=5, ch0 D=5 two cycles later, then sync.
      tbl.push_back(mk(0, 2'b11, 0, 5, 0, 2'b10, 2'b10, 2'b10));
      tbl.push_back(mk(0, 2'b11, 0, 5, 0, 2'b10, 2'b00, 2'b10));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b11, 2'b01, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 1, 2'b11, 2'b11, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(0, 2'b11, 5, 5, 0, 2'b11, 2'b11, 2'b11));
      // Sync with ch1 disabled mid-period.
      tbl.push_back(mk(0, 2'b01, 5, 5, 1, 2'b01, 2'b01, 2'b01));
      tbl.push_back(mk(0, 2'b01, 5, 5, 0, 2'b01, 2'b00, 2'b01));

      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

      // Asynchronous reset mid-period, no clock edge needed.
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async_reset", mk(1, 2'b01, 5, 5, 0, 2'b00, 2'b00, 2'b00));
      step("restart", mk(0, 2'b01, 5, 5, 0, 2'b01, 2'b01, 2'b01));

      // Maximum divisor 255: high 128, low 127, tick every 255.
      step("max_sync", mk(0, 2'b01, 255, 5, 1, 2'b01, 2'b01, 2'b01));
      for (int k = 1; k < 510; k++) begin
         logic c0, t0;
         c0 = ((k % 255) < 128);
         t0 = ((k % 255) == 0);
         step($sformatf("max%0d", k),
              mk(0, 2'b01, 255, 5, 0, {1'b0, c0}, {1'b0, t0}, 2'b01));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multi_channel_clock_divider.md
# multi_channel_clock_divider

Runtime-programmable, multi-channel clock divider. Each of NUM_CH channels divides clk_in by its own divisor, emits a divided clock-enable waveform plus a one-cycle tick at each period start, and supports odd divisors. Divisor changes and stop requests take effect only at period boundaries, so outputs never glitch. The block sits beside the system clock root and feeds baud, PWM and sampling logic that need several related slow rates with common phase alignment.

## Interface
- NUM_CH, 2, number of independent divider channels (≥1)
- WIDTH, 8, divisor width per channel in bits (≥2)

- clk_in  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  NUM_CH  per-channel run request
- divisor  input  NUM_CH*WIDTH  channel c divisor at bits [c*WIDTH +: WIDTH]; sampled only at period boundaries
- sync  input  1  synchronous phase-align strobe, all channels
- clk_out  output  NUM_CH  divided waveform, registered
- tick  output  NUM_CH  one-cycle pulse in the first cycle of each period
- running  output  NUM_CH  channel is active

## Operation
- Per channel state: running flag, active divisor D (WIDTH bits), counter cnt (WIDTH bits), registered clk_out and tick.
- Divisor valid iff value ≥ 2; values 0 and 1 are "stop".
- Idle (running=0): clk_out=0, tick=0, cnt=0. At a posedge with enable=1 and valid divisor: D←divisor, cnt←0, clk_out←1, tick←1, running←1.
- Running, cnt ≠ D−1: cnt←cnt+1; tick←0; clk_out←1 if (cnt+1) < H else 0, where H = ceil(D/2) = (D+1)>>1 computed at WIDTH+1 bits (no overflow at D=2^WIDTH−1).
- Running, cnt = D−1 (period boundary): if enable=1 and divisor valid → D←divisor, cnt←0, clk_out←1, tick←1; otherwise → idle (running←0, clk_out←0, tick←0, cnt←0).
- Result: high for ceil(D/2) cycles, low for floor(D/2); exact 50% for even D. D=2 toggles every cycle; D=3 is high 2, low 1.
- Mid-period changes to divisor or enable are ignored until the boundary; a period always completes and ends low.
- sync=1 (highest priority below reset): every channel with enable=1 and valid divisor restarts (D←divisor, cnt←0, clk_out←1, tick←1, running←1), regardless of phase; other channels go idle immediately (clk_out←0). Channels with the same divisor are therefore phase-aligned after sync.
- Channels otherwise fully independent.

## Timing
- Reset (async assert): clk_out=0, tick=0, running=0, cnt=0, D=0 for all channels; takes effect without a clock edge, including mid-period. After release, first start is at the first posedge meeting start conditions.
- Start latency: enable sampled at posedge k → clk_out/tick/running high from k (visible the cycle after k).
- Tick period = D cycles; tick coincides with the first high cycle of clk_out.
- Stop latency: at most D−1 cycles after enable falls (at the next boundary); running falls at that same edge.
- New divisor applies to the period that begins at the boundary edge; no partial periods.
- Simultaneous boundary and sync: sync behaviour applies (identical result for enabled channels).
- Width: cnt and D never exceed 2^WIDTH−1; comparison cnt = D−1 done at WIDTH bits (D ≥ 2 guaranteed).

## Test plan
- Reset: hold reset with enable=all ones, divisor=4 → clk_out, tick, running all 0; assert reset asynchronously mid-period → outputs 0 immediately, restart after release.
- Even/odd shape: ch0 D=4, ch1 D=3 → ch0 clk_out 1,1,0,0 repeating; ch1 1,1,0; ticks every 4 and 3 cycles respectively; D=2 → 1,0 toggle.
- Glitch-free update: ch0 running D=6, change divisor to 2 at cnt=1 → remaining cycles follow D=6 (1,1,1,0,0,0), then 1,0 pattern starts exactly at boundary with tick.
- Stop and invalid divisor: drop enable at cnt=1 of D=8 → 6 more cycles, clk_out ends low, running falls at boundary; divisor=0 or 1 with enable=1 → channel never starts.
- Sync alignment: ch0 D=5 and ch1 D=5 started 2 cycles apart, pulse sync → both tick on the same cycle afterward and stay aligned; disabled channel during sync → clk_out forced 0 next cycle.
- Max width: WIDTH=8, divisor=255 → high 128 cycles, low 127, tick period 255.
